// File: rtl/gated_counter_pkg.sv
// Shared types and constants for the gated multi-channel event counter.
package gated_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/gated_counter_bank_ch.sv
// One channel: input synchroniser, rising-edge detect, WIDTH-bit event counter and overflow flag.
module edge_counter_ch
    import gated_counter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_i,
    input  logic             count_en_i,
    input  logic             clear_i,
    input  logic             clear_to_one_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o
);

    localparam int NSYNC = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [NSYNC-1:0] sync_q;
    logic             prev_q;
    logic             edge_w;
    logic             inc_w;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    assign edge_w = sync_q[NSYNC-1] & ~prev_q;
    assign inc_w  = count_en_i & edge_w;

    // A clear coincides with the capture cycle; an edge arriving then opens the next gate at 1.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = (inc_w && clear_to_one_i) ? WIDTH'(1) : '0;
            ovf_d   = 1'b0;
        end else if (inc_w) begin
            if (&count_q) begin
                ovf_d   = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[NSYNC-2:0], sig_i};
            prev_q  <= sync_q[NSYNC-1];
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/gated_counter_bank.sv
// Multi-channel gated event counter: shared gate FSM, per-channel counters, capture and host handshake.
module gated_counter_bank
    import gated_counter_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIDTH       = 32,
    parameter int GATE_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       sig_in_i,
    input  logic [NCH-1:0]       ch_ena_i,
    input  logic [GATE_W-1:0]    gate_len_i,
    input  logic                 start_i,
    input  logic                 continuous_i,
    output logic                 busy_o,
    output logic [NCH*WIDTH-1:0] live_count_o,
    output logic [NCH*WIDTH-1:0] cap_count_o,
    output logic [NCH-1:0]       cap_ovf_o,
    output logic                 cap_valid_o,
    input  logic                 cap_ack_i,
    output logic                 cap_lost_o
);

    state_e               state_q, state_d;
    logic [GATE_W-1:0]    gate_cnt_q, gate_cnt_d;
    logic [GATE_W-1:0]    gate_load_w;
    logic [NCH*WIDTH-1:0] live_w;
    logic [NCH-1:0]       ovf_w;
    logic [NCH*WIDTH-1:0] cap_count_q, cap_count_d;
    logic [NCH-1:0]       cap_ovf_q, cap_ovf_d;
    logic                 cap_valid_q, cap_valid_d;
    logic                 cap_lost_q, cap_lost_d;
    logic                 count_en_w;
    logic                 capture_w;

    // Gate counter runs N-1 down to 0, so a zero length behaves as a one-cycle gate.
    assign gate_load_w = (gate_len_i == '0) ? '0 : gate_len_i - GATE_W'(1);
    assign capture_w   = (state_q == CAPTURE);
    assign count_en_w  = (state_q == GATE) || (capture_w && continuous_i);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_counter_ch #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .SATURATE    (SATURATE)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .sig_i          (sig_in_i[i]),
            .count_en_i     (count_en_w & ch_ena_i[i]),
            .clear_i        (capture_w),
            .clear_to_one_i (continuous_i),
            .count_o        (live_w[i*WIDTH +: WIDTH]),
            .ovf_o          (ovf_w[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        gate_cnt_d  = gate_cnt_q;
        cap_count_d = cap_count_q;
        cap_ovf_d   = cap_ovf_q;
        cap_valid_d = cap_valid_q;
        cap_lost_d  = cap_lost_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = GATE;
                    gate_cnt_d = gate_load_w;
                end
            end
            GATE: begin
                if (gate_cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    gate_cnt_d = gate_cnt_q - GATE_W'(1);
                end
            end
            CAPTURE: begin
                if (continuous_i) begin
                    state_d    = GATE;
                    gate_cnt_d = gate_load_w;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture outranks a simultaneous acknowledge; the ack only clears the loss flag.
        if (capture_w) begin
            cap_count_d = live_w;
            cap_ovf_d   = ovf_w;
            cap_valid_d = 1'b1;
            if (cap_ack_i) begin
                cap_lost_d = 1'b0;
            end else if (cap_valid_q) begin
                cap_lost_d = 1'b1;
            end
        end else if (cap_ack_i) begin
            cap_valid_d = 1'b0;
            cap_lost_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            cap_count_q <= '0;
            cap_ovf_q   <= '0;
            cap_valid_q <= 1'b0;
            cap_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            cap_count_q <= cap_count_d;
            cap_ovf_q   <= cap_ovf_d;
            cap_valid_q <= cap_valid_d;
            cap_lost_q  <= cap_lost_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign live_count_o = live_w;
    assign cap_count_o  = cap_count_q;
    assign cap_ovf_o    = cap_ovf_q;
    assign cap_valid_o  = cap_valid_q;
    assign cap_lost_o   = cap_lost_q;

endmodule

// File: tb/tb_gated_counter_bank.sv
// Bench for gated_counter_bank: wrap and saturate variants (WIDTH=4) driven in parallel against a cycle model.
module tb_gated_counter_bank;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int GW  = 8;

    logic          clk = 1'b0;
    logic          reset, start, continuous, cap_ack;
    logic [NCH-1:0] sig, ena;
    logic [GW-1:0]  glen;

    logic             busy0, busy1, valid0, valid1, lost0, lost1;
    logic [NCH*W-1:0] live0, live1, cap0, cap1;
    logic [NCH-1:0]   capovf0, capovf1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    gated_counter_bank #(.NCH(NCH), .WIDTH(W), .GATE_W(GW), .SYNC_STAGES(2), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .sig_in_i(sig), .ch_ena_i(ena), .gate_len_i(glen),
        .start_i(start), .continuous_i(continuous), .busy_o(busy0), .live_count_o(live0),
        .cap_count_o(cap0), .cap_ovf_o(capovf0), .cap_valid_o(valid0), .cap_ack_i(cap_ack),
        .cap_lost_o(lost0));

    gated_counter_bank #(.NCH(NCH), .WIDTH(W), .GATE_W(GW), .SYNC_STAGES(2), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .sig_in_i(sig), .ch_ena_i(ena), .gate_len_i(glen),
        .start_i(start), .continuous_i(continuous), .busy_o(busy1), .live_count_o(live1),
        .cap_count_o(cap1), .cap_ovf_o(capovf1), .cap_valid_o(valid1), .cap_ack_i(cap_ack),
        .cap_lost_o(lost1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0=idle 1=gate 2=capture; m_left = gate cycles still to run.
    int m_phase, m_left;
    int m_cnt[2][NCH];
    int m_cap[2][NCH];
    bit m_ovf[2][NCH];
    bit m_capovf[2][NCH];
    bit m_valid, m_lost;
    logic [NCH-1:0] d1, d2, d3;
    logic [NCH-1:0] m_edge;
    bit m_on, m_inc;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_left = 0; m_valid = 0; m_lost = 0;
            for (int v = 0; v < 2; v++)
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[v][c] = 0; m_cap[v][c] = 0; m_ovf[v][c] = 0; m_capovf[v][c] = 0;
                end
            d1 = '0; d2 = '0; d3 = '0;
        end else begin
            // An input level first sampled high two edges ago (low three ago) is counted now.
            m_edge = d2 & ~d3;
            m_on   = (m_phase == 1) || (m_phase == 2 && continuous);
            for (int v = 0; v < 2; v++)
                for (int c = 0; c < NCH; c++) begin
                    m_inc = m_on && ena[c] && m_edge[c];
                    if (m_phase == 2) begin
                        m_cap[v][c]    = m_cnt[v][c];
                        m_capovf[v][c] = m_ovf[v][c];
                        m_cnt[v][c]    = m_inc ? 1 : 0;
                        m_ovf[v][c]    = 0;
                    end else if (m_inc) begin
                        if (m_cnt[v][c] == (1 << W) - 1) begin
                            m_ovf[v][c] = 1;
                            m_cnt[v][c] = (v == 1) ? m_cnt[v][c] : 0;
                        end else begin
                            m_cnt[v][c] = m_cnt[v][c] + 1;
                        end
                    end
                end
            if (m_phase == 2) begin
                m_lost  = cap_ack ? 1'b0 : (m_valid ? 1'b1 : m_lost);
                m_valid = 1;
            end else if (cap_ack) begin
                m_valid = 0; m_lost = 0;
            end
            case (m_phase)
                0: if (start) begin m_phase = 1; m_left = (glen == 0) ? 1 : int'(glen); end
                1: if (m_left == 1) m_phase = 2; else m_left = m_left - 1;
                default: begin
                    if (continuous) begin m_phase = 1; m_left = (glen == 0) ? 1 : int'(glen); end
                    else m_phase = 0;
                end
            endcase
            d3 = d2; d2 = d1; d1 = sig;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0", busy0, m_phase != 0);
            chk("busy1", busy1, m_phase != 0);
            chk("valid0", valid0, m_valid);
            chk("valid1", valid1, m_valid);
            chk("lost0", lost0, m_lost);
            chk("lost1", lost1, m_lost);
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("live0_ch%0d", c), live0[c*W +: W], m_cnt[0][c]);
                chk($sformatf("live1_ch%0d", c), live1[c*W +: W], m_cnt[1][c]);
                chk($sformatf("cap0_ch%0d", c), cap0[c*W +: W], m_cap[0][c]);
                chk($sformatf("cap1_ch%0d", c), cap1[c*W +: W], m_cap[1][c]);
                chk($sformatf("capovf0_ch%0d", c), capovf0[c], m_capovf[0][c]);
                chk($sformatf("capovf1_ch%0d", c), capovf1[c], m_capovf[1][c]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        sig = m; tick(1);
        sig = '0; tick(1);
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (valid0 !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        chk(nm, k < 300, 1);
    endtask

    initial begin
        reset = 1; start = 0; continuous = 0; cap_ack = 0; sig = '0; ena = '0; glen = '0;
        tick(1);
        chk_en = 1;
        tick(2);
        reset = 0;
        chk("rst_busy", busy0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_live", live0, 0);
        chk("rst_cap", cap1, 0);

        // Single-shot gate of 100, ten pulses on every channel, ch2 disabled.
        glen = 8'd100; ena = 4'b1011;
        start = 1; tick(1); start = 0;
        sig = 4'hF; tick(1);
        chk("lat_1", live0[3:0], 0);
        sig = '0; tick(1);
        chk("lat_2", live0[3:0], 0);
        tick(1);
        chk("lat_3", live0[3:0], 1);
        repeat (9) pulse(4'hF);
        wait_valid("t1_timeout");
        chk("t1_cap_ch0", cap0[3:0], 10);
        chk("t1_cap_ch2_off", cap0[11:8], 0);
        chk("t1_cap1_ch3", cap1[15:12], 10);
        chk("t1_valid", valid0, 1);
        cap_ack = 1; tick(1); cap_ack = 0;
        chk("t1_acked", valid0, 0);

        // Sixteen pulses into a 4-bit counter: wrap vs saturate, overflow flagged.
        glen = 8'd40; ena = 4'hF;
        start = 1; tick(1); start = 0;
        repeat (16) pulse(4'b0010);
        wait_valid("t3_timeout");
        chk("t3_wrap_cnt", cap0[7:4], 0);
        chk("t3_wrap_ovf", capovf0[1], 1);
        chk("t3_sat_cnt", cap1[7:4], 15);
        chk("t3_sat_ovf", capovf1[1], 1);
        cap_ack = 1; tick(1); cap_ack = 0;

        // Continuous gates of 10: ch2 counted on the last gate cycle, ch3 on the capture cycle.
        continuous = 1; glen = 8'd10;
        start = 1; tick(1); start = 0;
        tick(7);
        sig[2] = 1'b1; tick(1);
        sig[3] = 1'b1; tick(1);
        sig = '0; tick(2);
        chk("t2_gk_ch2", cap0[11:8], 1);
        chk("t2_gk_ch3", cap0[15:12], 0);
        chk("t2_live_ch3", live0[15:12], 1);
        chk("t2_lost_first", lost0, 0);
        tick(10);
        continuous = 0; tick(1);
        chk("t2_gk1_ch3", cap0[15:12], 1);
        chk("t2_gk1_ch2", cap0[11:8], 0);
        chk("t4_lost", lost0, 1);
        chk("t4_idle", busy0, 0);
        cap_ack = 1; tick(1); cap_ack = 0;
        chk("t4_ack_valid", valid0, 0);
        chk("t4_ack_lost", lost1, 0);

        // Zero-length gate with start held high through the busy period.
        glen = 8'd0;
        start = 1; tick(1);
        chk("t5_busy_a", busy0, 1);
        tick(1);
        chk("t5_busy_b", busy0, 1);
        tick(1);
        start = 0;
        chk("t5_done", busy0, 0);
        chk("t5_valid", valid0, 1);
        tick(1);
        chk("t5_ignored", busy0, 0);

        // Capture while a previous capture is pending, acknowledged in the capture cycle.
        glen = 8'd2;
        start = 1; tick(1); start = 0;
        tick(2);
        cap_ack = 1; tick(1); cap_ack = 0;
        chk("ack_same_valid", valid0, 1);
        chk("ack_same_lost", lost0, 0);

        // Reset mid-gate with every input held high.
        glen = 8'd50; ena = 4'hF;
        start = 1; tick(1); start = 0;
        sig = 4'hF; tick(5);
        chk("t6_pre_live", live0, 16'h1111);
        reset = 1; tick(1); reset = 0;
        chk("t6_busy", busy0, 0);
        chk("t6_live", live0, 0);
        chk("t6_cap", cap0, 0);
        chk("t6_valid", valid0, 0);
        tick(10);
        chk("t6_still_live", live1, 0);
        chk("t6_still_busy", busy1, 0);
        sig = '0; tick(3);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
